// File: rtl/branch_pkg.sv
// Shared definitions for the branch/PC unit: flag layout, strobe priority,
// default return-stack depth and the decoder's branch opcode encodings.
package branch_pkg;

    // Bit positions inside the 4-bit flag register {V,S,C,Z}.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 3;

    localparam int RAS_DEPTH_DEFAULT = 8;

    // Control strobes, one enumerator per decoder output.
    typedef enum logic [3:0] {
        STB_RET, STB_CALL, STB_BR, STB_B,
        STB_BZ, STB_BNZ, STB_BCY, STB_BNCY,
        STB_BS, STB_BNS, STB_BV, STB_BNV
    } strobe_e;

    // Resolution order when several strobes are high, highest first.
    localparam strobe_e STROBE_PRIO [12] = '{
        STB_RET, STB_CALL, STB_BR, STB_B,
        STB_BZ, STB_BNZ, STB_BCY, STB_BNCY,
        STB_BS, STB_BNS, STB_BV, STB_BNV
    };

    // 6-bit branch opcodes as emitted by the decoder.
    localparam logic [5:0] OP_B    = 6'b010100;
    localparam logic [5:0] OP_BR   = 6'b010101;
    localparam logic [5:0] OP_BZ   = 6'b010110;
    localparam logic [5:0] OP_BNZ  = 6'b010111;
    localparam logic [5:0] OP_BCY  = 6'b011000;
    localparam logic [5:0] OP_BNCY = 6'b011001;
    localparam logic [5:0] OP_BS   = 6'b011010;
    localparam logic [5:0] OP_BNS  = 6'b011011;
    localparam logic [5:0] OP_BV   = 6'b011100;
    localparam logic [5:0] OP_BNV  = 6'b011101;
    localparam logic [5:0] OP_CALL = 6'b011110;
    localparam logic [5:0] OP_RET  = 6'b011111;

endpackage

// File: rtl/branch_pc_unit_ret_addr_stack.sv
// Hardware return-address stack. A push onto a full stack overwrites the
// oldest entry (the write pointer has wrapped onto it); the count saturates.
module ret_addr_stack
    import branch_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;      // next slot to write
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] ptr_dec;  // current top of stack

    assign ptr_dec = ptr - {{(PTR_W-1){1'b0}}, 1'b1};
    assign dout    = mem[ptr_dec];
    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(RAS_DEPTH));

    // Pointer and occupancy; pop wins if both are requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (pop) begin
            if (!empty) begin
                ptr   <= ptr_dec;
                count <= count - 1'b1;
            end
        end else if (push) begin
            ptr <= ptr + 1'b1;
            if (!full) begin
                count <= count + 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push && !pop) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter, flag register and return-address stack. Resolves the
// decoder strobes for the instruction at pc into the next pc, one cycle later.
module branch_pc_unit
    import branch_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              RAS_DEPTH = RAS_DEPTH_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            b,
    input  logic            br,
    input  logic            bz,
    input  logic            bnz,
    input  logic            bcy,
    input  logic            bncy,
    input  logic            bs,
    input  logic            bns,
    input  logic            bv,
    input  logic            bnv,
    input  logic            Call,
    input  logic            Ret,
    input  logic [PC_W-1:0] imm_target,
    input  logic [PC_W-1:0] reg_target,
    input  logic            flag_we,
    input  logic            alu_zero,
    input  logic            alu_carry,
    input  logic            alu_sign,
    input  logic            alu_overflow,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      flags,
    output logic            taken,
    output logic            flush,
    output logic            ras_ovf,
    output logic            ras_unf
);

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] ras_dout;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_push;
    logic            ras_pop;
    logic            cond_true;
    logic            ovf_set;
    logic            unf_set;

    // Natural wrap of the adder gives all-ones + 1 = 0.
    assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};

    // Only the highest-priority conditional strobe is evaluated, always
    // against the registered flags.
    always_comb begin
        cond_true = 1'b0;
        if      (bz)   cond_true =  flags[FLAG_Z];
        else if (bnz)  cond_true = ~flags[FLAG_Z];
        else if (bcy)  cond_true =  flags[FLAG_C];
        else if (bncy) cond_true = ~flags[FLAG_C];
        else if (bs)   cond_true =  flags[FLAG_S];
        else if (bns)  cond_true = ~flags[FLAG_S];
        else if (bv)   cond_true =  flags[FLAG_V];
        else if (bnv)  cond_true = ~flags[FLAG_V];
    end

    // Next-pc selection in strobe priority order; a stall cancels everything.
    always_comb begin
        pc_next  = pc_inc;
        taken    = 1'b0;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (Ret) begin
            if (!ras_empty) begin
                ras_pop = 1'b1;
                pc_next = ras_dout;
                taken   = 1'b1;
            end else begin
                unf_set = 1'b1;
            end
        end else if (Call) begin
            ras_push = 1'b1;
            ovf_set  = ras_full;
            pc_next  = imm_target;
            taken    = 1'b1;
        end else if (br) begin
            pc_next = reg_target;
            taken   = 1'b1;
        end else if (b || cond_true) begin
            pc_next = imm_target;
            taken   = 1'b1;
        end
        if (stall) begin
            pc_next  = pc;
            taken    = 1'b0;
            ras_push = 1'b0;
            ras_pop  = 1'b0;
            ovf_set  = 1'b0;
            unf_set  = 1'b0;
        end
    end

    // Architectural state: pc, flags, flush pulse and sticky RAS errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            flags   <= 4'b0000;
            flush   <= 1'b0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            pc    <= pc_next;
            flush <= taken;
            if (flag_we && !stall) begin
                flags <= {alu_overflow, alu_sign, alu_carry, alu_zero};
            end
            if (ovf_set) ras_ovf <= 1'b1;
            if (unf_set) ras_unf <= 1'b1;
        end
    end

    ret_addr_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_inc),
        .dout  (ras_dout),
        .empty (ras_empty),
        .full  (ras_full)
    );

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: reference model plus expected-state queue,
// directed scenarios followed by a random strobe mix.
module tb_branch_pc_unit;
    import branch_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst, stall;
    logic         b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, call_s, ret_s;
    logic [W-1:0] imm_target, reg_target;
    logic         flag_we, alu_zero, alu_carry, alu_sign, alu_overflow;
    logic [W-1:0] pc;
    logic [3:0]   flags;
    logic         taken, flush, ras_ovf, ras_unf;

    branch_pc_unit #(.PC_W(W), .RAS_DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .b(b), .br(br), .bz(bz), .bnz(bnz), .bcy(bcy), .bncy(bncy),
        .bs(bs), .bns(bns), .bv(bv), .bnv(bnv), .Call(call_s), .Ret(ret_s),
        .imm_target(imm_target), .reg_target(reg_target), .flag_we(flag_we),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign),
        .alu_overflow(alu_overflow),
        .pc(pc), .flags(flags), .taken(taken), .flush(flush),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    // clock
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // expected {pc, flags, flush, ras_ovf, ras_unf}
    logic [W+6:0] exp_q [$];

    // reference model state
    logic [W-1:0] m_pc;
    logic [3:0]   m_flags;
    logic         m_flush, m_ovf, m_unf;
    logic [W-1:0] m_ras [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec = n_vec + 1;
        if (got !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // strobe vector bit k corresponds to opcode OP_B + k
    function automatic logic [11:0] stb_of(input logic [5:0] opc);
        logic [11:0] one;
        one = 12'd1;
        return one << (opc - OP_B);
    endfunction

    // Drive one cycle, predict, then compare the registered result.
    task automatic step(input logic [11:0] stb, input logic [W-1:0] imm,
                        input logic [W-1:0] rtgt, input logic fwe,
                        input logic [3:0] alu, input logic stl, input logic rs);
        logic         exp_taken;
        logic [W-1:0] nxt;
        logic [W+6:0] want;
        int           k;
        @(negedge clk);
        b = stb[0]; br = stb[1]; bz = stb[2]; bnz = stb[3];
        bcy = stb[4]; bncy = stb[5]; bs = stb[6]; bns = stb[7];
        bv = stb[8]; bnv = stb[9]; call_s = stb[10]; ret_s = stb[11];
        imm_target = imm; reg_target = rtgt; flag_we = fwe;
        {alu_overflow, alu_sign, alu_carry, alu_zero} = alu;
        stall = stl; rst = rs;
        #1;
        exp_taken = 1'b0;
        nxt = m_pc + 1;
        if (rs) begin
            m_pc = '0; m_flags = '0; m_flush = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            m_ras.delete();
        end else if (stl) begin
            check("taken_stall", taken, 0);
            m_flush = 1'b0;
        end else begin
            if (stb[11]) begin
                if (m_ras.size() > 0) begin
                    nxt = m_ras.pop_back();
                    exp_taken = 1'b1;
                end else begin
                    m_unf = 1'b1;
                end
            end else if (stb[10]) begin
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_ras.push_back(m_pc + 1);
                nxt = imm; exp_taken = 1'b1;
            end else if (stb[1]) begin
                nxt = rtgt; exp_taken = 1'b1;
            end else if (stb[0]) begin
                nxt = imm; exp_taken = 1'b1;
            end else begin
                k = 2;
                while (k <= 9 && !stb[k]) k++;
                if (k <= 9 && (m_flags[(k-2)>>1] == ((k % 2) == 0))) begin
                    nxt = imm; exp_taken = 1'b1;
                end
            end
            check("taken", taken, exp_taken);
            if (fwe) m_flags = alu;
            m_pc = nxt;
            m_flush = exp_taken;
        end
        exp_q.push_back({m_pc, m_flags, m_flush, m_ovf, m_unf});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 1, 0);
        end else begin
            want = exp_q.pop_front();
            check("pc", pc, want[W+6:7]);
            check("flags", flags, want[6:3]);
            check("flush", flush, want[2]);
            check("ras_ovf", ras_ovf, want[1]);
            check("ras_unf", ras_unf, want[0]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic op(input logic [5:0] opc, input logic [W-1:0] imm);
        step(stb_of(opc), imm, '0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        m_pc = '0; m_flags = '0; m_flush = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

        // reset, then free-running pc 0..4
        step('0, '0, '0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("reset_pc", pc, 0);
        idle(4);
        check("pc_after_4", pc, 4);
        idle(1);

        // flags latched at pc=5, bz at pc=6 sees Z=1
        step('0, '0, '0, 1'b1, 4'b0001, 1'b0, 1'b0);
        op(OP_BZ, 32'h40);
        check("bz_pc", pc, 32'h40);
        check("bz_flush", flush, 1);
        op(OP_B, 32'h6);
        op(OP_BNZ, 32'h40);
        check("bnz_pc", pc, 32'h7);
        check("bnz_flush", flush, 0);

        // nested call / return
        op(OP_B, 32'h10);
        op(OP_CALL, 32'h100);
        check("call1", pc, 32'h100);
        idle(1);
        op(OP_CALL, 32'h200);
        check("call2", pc, 32'h200);
        op(OP_RET, '0);
        check("ret1", pc, 32'h102);
        op(OP_RET, '0);
        check("ret2", pc, 32'h11);

        // nine calls overflow an 8-deep stack; nine returns underflow it
        for (int i = 0; i < 9; i++) op(OP_CALL, 32'h300 + 32'(i) * 32'h10);
        check("ovf_sticky", ras_ovf, 1);
        for (int j = 0; j < 8; j++) begin
            op(OP_RET, '0);
            check("ret_lifo", pc, 32'h371 - 32'(j) * 32'h10);
        end
        op(OP_RET, '0);
        check("ret_empty_pc", pc, 32'h302);
        check("unf_sticky", ras_unf, 1);

        // stall holds everything despite b and flag_we
        for (int i = 0; i < 3; i++) step(stb_of(OP_B), 32'h80, '0, 1'b1, 4'hE, 1'b1, 1'b0);
        check("stall_pc", pc, 32'h302);
        check("stall_flags", flags, 4'b0001);
        op(OP_B, 32'h80);
        check("post_stall_b", pc, 32'h80);

        // Call beats br at all-ones pc; return address wraps to 0
        op(OP_B, 32'hFFFF_FFFF);
        step(stb_of(OP_CALL) | stb_of(OP_BR), 32'h500, 32'h600, 1'b0, 4'h0, 1'b0, 1'b0);
        check("call_over_br", pc, 32'h500);
        op(OP_RET, '0);
        check("wrapped_ret", pc, 0);

        // reset during a Call wins and empties the stack
        op(OP_CALL, 32'h700);
        step(stb_of(OP_CALL), 32'h800, '0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("rst_mid_pc", pc, 0);
        check("rst_mid_ovf", ras_ovf, 0);
        op(OP_RET, '0);
        check("rst_ras_empty", pc, 1);

        // random strobe mix
        for (int i = 0; i < 200; i++) begin
            logic [11:0] s;
            s = '0;
            if ($urandom_range(0, 3) != 0) s = stb_of(6'($urandom_range(20, 31)));
            if ($urandom_range(0, 4) == 0) s = s | stb_of(6'($urandom_range(20, 31)));
            step(s, $urandom, $urandom, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
